// File: rtl/sym_fir_pkg.sv
// rtl/sym_fir_pkg.sv - shared defaults, sizing helpers and round/saturate for the symmetric FIR
package sym_fir_pkg;

  localparam int NTAPS_DEF = 21;
  localparam int DW_DEF    = 18;
  localparam int CW_DEF    = 18;

  // b[0] sits in the least significant CW bits
  localparam logic [11*18-1:0] COEF_INIT_DEF = {
    18'sd26705, 18'sd23244, 18'sd14679, 18'sd5221, -18'sd1270, -18'sd3419,
    -18'sd2451, -18'sd632, 18'sd459, 18'sd566, 18'sd242
  };

  function automatic int nu_of(input int ntaps);
    return (ntaps + 1) / 2;
  endfunction

  function automatic int guard_bits(input int nu);
    return $clog2(nu);
  endfunction

  // Round half-up at bit cf, then clamp into a signed dw-bit range
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int cf, input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (cf - 1))) >>> cf;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// rtl/fir_coef_bank.sv - shadow/active coefficient banks with indexed write and bulk swap
module fir_coef_bank
  import sym_fir_pkg::*;
#(
  parameter int                NU        = nu_of(NTAPS_DEF),
  parameter int                CW        = CW_DEF,
  parameter logic [NU*CW-1:0]  COEF_INIT = COEF_INIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 coef_we,
  input  logic [5:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic [NU*CW-1:0]     active_flat
);

  localparam int AW = (NU > 1) ? $clog2(NU) : 1;

  logic signed [CW-1:0] shadow [NU];
  logic signed [CW-1:0] active [NU];

  // Swap reads the pre-edge shadow, so a write in the same cycle lands only in shadow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NU; i++) begin
        shadow[i] <= COEF_INIT[i*CW +: CW];
        active[i] <= COEF_INIT[i*CW +: CW];
      end
    end else begin
      if (coef_swap) begin
        for (int i = 0; i < NU; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (coef_we && (int'(coef_addr) < NU)) begin
        shadow[coef_addr[AW-1:0]] <= coef_data;
      end
    end
  end

  always_comb begin
    active_flat = '0;
    for (int i = 0; i < NU; i++) begin
      active_flat[i*CW +: CW] = active[i];
    end
  end

endmodule

// File: rtl/sym_fir_pipe.sv
// rtl/sym_fir_pipe.sv - symmetric FIR: pre-add, multiply, accumulate, round/saturate pipeline
module sym_fir_pipe
  import sym_fir_pkg::*;
#(
  parameter int                          NTAPS     = NTAPS_DEF,
  parameter int                          DW        = DW_DEF,
  parameter int                          CW        = CW_DEF,
  parameter logic [nu_of(NTAPS)*CW-1:0]  COEF_INIT = COEF_INIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [5:0]           coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic                 out_valid,
  output logic signed [DW-1:0] y
);

  localparam int NU = nu_of(NTAPS);
  localparam int G  = guard_bits(NU);
  localparam int PW = DW + 1;
  localparam int MW = PW + CW;
  localparam int AW = MW + G;
  localparam int CF = CW - 1;

  logic [NU*CW-1:0]     active_flat;
  logic signed [DW-1:0] dly  [NTAPS-1];
  logic signed [DW-1:0] win  [NTAPS];
  logic signed [CW-1:0] coef [NU];
  logic signed [PW-1:0] pre  [NU];
  logic signed [MW-1:0] prod [NU];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sum;
  logic [2:0]           vld;

  fir_coef_bank #(
    .NU        (NU),
    .CW        (CW),
    .COEF_INIT (COEF_INIT)
  ) u_coef_bank (
    .clk         (clk),
    .reset_n     (reset_n),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_swap   (coef_swap),
    .active_flat (active_flat)
  );

  // win is the delay line as it will be after this cycle's shift, so pre-add sees x_in now
  always_comb begin
    win[0] = x_in;
    for (int i = 1; i < NTAPS; i++) begin
      win[i] = dly[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NU; i++) begin
      coef[i] = active_flat[i*CW +: CW];
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < NU; i++) begin
      acc_sum = acc_sum + AW'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS - 1; i++) begin
        dly[i] <= '0;
      end
      for (int i = 0; i < NU; i++) begin
        pre[i]  <= '0;
        prod[i] <= '0;
      end
      acc       <= '0;
      vld       <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      vld       <= {vld[1:0], in_valid};
      out_valid <= vld[2];
      if (in_valid) begin
        dly[0] <= x_in;
        for (int i = 1; i < NTAPS - 1; i++) begin
          dly[i] <= dly[i-1];
        end
        for (int i = 0; i < NU - 1; i++) begin
          pre[i] <= PW'(win[i]) + PW'(win[NTAPS-1-i]);
        end
        pre[NU-1] <= PW'(win[NU-1]);
      end
      if (vld[0]) begin
        for (int i = 0; i < NU; i++) begin
          prod[i] <= MW'(pre[i]) * MW'(coef[i]);
        end
      end
      if (vld[1]) begin
        acc <= acc_sum;
      end
      if (vld[2]) begin
        y <= DW'(round_sat(64'(acc), CF, DW));
      end
    end
  end

endmodule

// File: tb/tb_sym_fir_pipe.sv
// tb/tb_sym_fir_pipe.sv - scoreboard bench for sym_fir_pipe against a direct-form reference
module tb_sym_fir_pipe;

  localparam int NT = 21;
  localparam int NU = 11;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [17:0]  x_in = '0;
  logic                coef_we = 1'b0;
  logic [5:0]          coef_addr = '0;
  logic signed [17:0]  coef_data = '0;
  logic                coef_swap = 1'b0;
  logic                out_valid;
  logic signed [17:0]  y;

  sym_fir_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_swap (coef_swap),
    .out_valid (out_valid),
    .y         (y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     due;
    longint val;
  } exp_t;

  exp_t   q[$];
  longint cap[$];
  bit     cap_en = 1'b0;
  int     n_tests = 0;
  int     n_fail = 0;
  longint prev_y = 0;
  bit     prev_rst = 1'b0;

  int     ci [NU] = '{242, 566, 459, -632, -2451, -3419, -1270, 5221, 14679, 23244, 26705};
  longint xm  [NT];
  longint act [NU];
  longint shd [NU];

  task automatic chk(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic int hval(input int k);
    return ci[(k < NU) ? k : NT - 1 - k];
  endfunction

  // Direct-form convolution over the full symmetric impulse response
  function automatic longint ref_y();
    longint a;
    longint r;
    a = 0;
    for (int k = 0; k < NT; k++) begin
      a += xm[k] * act[(k < NU) ? k : NT - 1 - k];
    end
    r = (a + 65536) >>> 17;
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NT; k++) xm[k] = 0;
    for (int i = 0; i < NU; i++) begin
      act[i] = ci[i];
      shd[i] = ci[i];
    end
  endfunction

  task automatic tick(input bit v, input int xv, input bit we, input int addr,
                      input int data, input bit sw);
    @(negedge clk);
    in_valid  = v;
    x_in      = 18'(xv);
    coef_we   = we;
    coef_addr = 6'(addr);
    coef_data = 18'(data);
    coef_swap = sw;
    if (sw) begin
      for (int i = 0; i < NU; i++) act[i] = shd[i];
    end
    if (we && addr < NU) shd[addr] = data;
    if (v) begin
      for (int k = NT - 1; k > 0; k--) xm[k] = xm[k-1];
      xm[0] = xv;
      q.push_back('{due: cyc + 4, val: ref_y()});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    coef_swap = 1'b0;
    q.delete();
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("reset_y", y, 0);
      chk("reset_out_valid", out_valid, 0);
    end
    reset_n = 1'b1;
  endtask

  task automatic impulse_run(input int gap, input string tag);
    for (int i = 0; i < NT; i++) tick(1, 0, 0, 0, 0, 0);
    idle(6);
    cap.delete();
    cap_en = 1'b1;
    for (int i = 0; i < NT; i++) begin
      tick(1, (i == 0) ? 131071 : 0, 0, 0, 0, 0);
      idle(gap);
    end
    idle(6);
    cap_en = 1'b0;
    chk({tag, "_count"}, cap.size(), NT);
    for (int k = 0; k < NT && k < cap.size(); k++) begin
      chk({tag, "_tap"}, cap[k], hval(k));
    end
  endtask

  task automatic rand_valids(input int n);
    for (int i = 0; i < n; i++) tick(1, int'($urandom_range(0, 262143)) - 131072, 0, 0, 0, 0);
  endtask

  // Monitor: every out_valid pops one expectation; silent cycles must hold y
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && prev_rst) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got y=%0d at cycle %0d, want no output", y, cyc);
          end else begin
            e = q.pop_front();
            chk("out_valid_cycle", cyc, e.due);
            chk("y_value", y, e.val);
          end
          if (cap_en) cap.push_back(longint'(y));
        end else begin
          chk("y_hold", y, prev_y);
          if (q.size() != 0 && q[0].due <= cyc) begin
            chk("out_valid_due", out_valid, 1);
            void'(q.pop_front());
          end
        end
      end
      prev_y   = y;
      prev_rst = reset_n;
    end
  end

  initial begin
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("init_y", y, 0);
      chk("init_out_valid", out_valid, 0);
    end
    reset_n = 1'b1;

    impulse_run(0, "impulse");
    impulse_run(2, "gapped");

    for (int i = 0; i < NT + 4; i++) tick(1, 131071, 0, 0, 0, 0);
    idle(6);
    chk("dc_settle", y, 99982);

    for (int a = 0; a < NU; a++) tick(0, 0, 1, a, 131071, 0);
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NT + 4; i++) tick(1, 131071, 0, 0, 0, 0);
    idle(6);
    chk("sat_pos", y, 131071);
    for (int i = 0; i < NT + 4; i++) tick(1, -131072, 0, 0, 0, 0);
    idle(6);
    chk("sat_neg", y, -131072);

    // Mid-stream swap carrying a same-cycle write that must wait for the next swap
    for (int a = 0; a < NU; a++) tick(0, 0, 1, a, int'($urandom_range(0, 65535)) - 32768, 0);
    rand_valids(10);
    tick(1, int'($urandom_range(0, 262143)) - 131072, 1, 3, 30000, 1);
    rand_valids(10);
    tick(1, int'($urandom_range(0, 262143)) - 131072, 1, 20, 12345, 1);
    rand_valids(10);
    idle(6);

    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 3) != 0, int'($urandom_range(0, 262143)) - 131072,
           ($urandom % 8) == 0, int'($urandom % 16),
           int'($urandom_range(0, 131071)) - 65536, ($urandom % 20) == 0);
    end

    rand_valids(8);
    do_reset(2);
    impulse_run(0, "post_reset");

    idle(8);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
